// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct3/funct7 encodings and the operation bundle fed to the ALU.
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic        imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response channels of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_imm;
  logic [3*NUM_REQ-1:0]  req_funct3;
  logic [7*NUM_REQ-1:0]  req_funct7;
  logic [32*NUM_REQ-1:0] req_rs1;
  logic [32*NUM_REQ-1:0] req_rs2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_rd;
  logic [31:0]           grant_cnt;

  modport master (
    output req_valid, req_imm, req_funct3, req_funct7, req_rs1, req_rs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_rd, grant_cnt
  );

  modport slave (
    input  req_valid, req_imm, req_funct3, req_funct7, req_rs1, req_rs2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_rd, grant_cnt
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32I-style integer ALU; unsupported encodings return 0.
module alu
  import alu_pkg::*;
(
  input  alu_op_t     op,
  output logic [31:0] rd
);

  logic [6:0] mode;
  logic [4:0] shamt;

  // Decode the operation; for I-type shifts the mode bits live in imm[11:5].
  always_comb begin
    mode  = op.imm ? op.rs2[11:5] : op.funct7;
    shamt = op.rs2[4:0];
    rd    = '0;
    case (op.funct3)
      F3_ADD: begin
        if (op.imm || op.funct7 == F7_BASE) rd = op.rs1 + op.rs2;
        else if (op.funct7 == F7_ALT)       rd = op.rs1 - op.rs2;
      end
      F3_SLL:  if (mode == F7_BASE) rd = op.rs1 << shamt;
      F3_SLT:  if (op.imm || op.funct7 == F7_BASE)
                 rd = {31'b0, $signed(op.rs1) < $signed(op.rs2)};
      F3_SLTU: if (op.imm || op.funct7 == F7_BASE) rd = {31'b0, op.rs1 < op.rs2};
      F3_XOR:  if (op.imm || op.funct7 == F7_BASE) rd = op.rs1 ^ op.rs2;
      F3_SR: begin
        if (mode == F7_BASE)     rd = op.rs1 >> shamt;
        else if (mode == F7_ALT) rd = $unsigned($signed(op.rs1) >>> shamt);
      end
      F3_OR:   if (op.imm || op.funct7 == F7_BASE) rd = op.rs1 | op.rs2;
      F3_AND:  if (op.imm || op.funct7 == F7_BASE) rd = op.rs1 & op.rs2;
      default: rd = '0;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_idx
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;

  // Rotate so rr_ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    doubled     = {req_valid, req_valid};
    rotated     = NUM_REQ'(doubled >> rr_ptr);
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Descending scan: the lowest offset is assigned last and wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        grant_valid = 1'b1;
        grant_idx   = ((int'(rr_ptr) + k) >= int'(NUM_REQ)) ?
                      ID_W'(int'(rr_ptr) + k - int'(NUM_REQ)) : ID_W'(int'(rr_ptr) + k);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a
// single registered, tagged response with backpressure.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [31:0]        rsp_rd_q;
  logic [31:0]        grant_cnt_q;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic               can_accept;
  logic               fire;
  logic [NUM_REQ-1:0] req_ready_d;
  alu_op_t            op;
  logic [31:0]        alu_rd;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req_valid   (bus.req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  alu u_alu (
    .op (op),
    .rd (alu_rd)
  );

  // Handshake, operand mux and pointer advance for the granted requester.
  always_comb begin
    can_accept  = !rsp_valid_q || bus.rsp_ready;
    fire        = grant_valid && can_accept && !rst;
    req_ready_d = '0;
    if (fire) req_ready_d[grant_idx] = 1'b1;
    op.imm    = bus.req_imm[grant_idx];
    op.funct3 = bus.req_funct3[int'(grant_idx) * 3 +: 3];
    op.funct7 = bus.req_funct7[int'(grant_idx) * 7 +: 7];
    op.rs1    = bus.req_rs1[int'(grant_idx) * 32 +: 32];
    op.rs2    = bus.req_rs2[int'(grant_idx) * 32 +: 32];
    rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Response register, round-robin pointer and accepted-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rd_q    <= '0;
      grant_cnt_q <= '0;
    end else if (fire) begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= grant_idx;
      rsp_rd_q    <= alu_rd;
      grant_cnt_q <= grant_cnt_q + 32'd1;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.grant_cnt = grant_cnt_q;

endmodule
